digit_entry: RTL and testbench

Parametrised multi-digit code-entry block for the voting-machine front end. It debounces-by-edge three push keys, builds an NDIG-digit BCD code one digit at a time, and drives one active-low 7-segment display per digit. A review/confirm step commits the code with a one-cycle `done` pulse. It generalises the two-key, two-display digit module to N digits, adds a correction key and a confirm handshake, and runs on a single clock.

---
 rtl/digit_entry.sv | 146 ++++++++++++++
 tb/tb_digit_entry.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/digit_entry.sv
// Multi-digit BCD code entry: three edge-detected push keys edit NDIG digits,
// a review step commits the code with a one-cycle done pulse.
module digit_entry #(
   parameter int NDIG   = 2,
   parameter int MAXVAL = 9,
   localparam int CW    = (NDIG > 1) ? $clog2(NDIG) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 key1,
   input  logic                 key2,
   input  logic                 key3,
   output logic [4*NDIG-1:0]    bcd,
   output logic [7*NDIG-1:0]    hex,
   output logic [CW-1:0]        cursor,
   output logic                 review,
   output logic [4*NDIG-1:0]    code,
   output logic                 done
);

   localparam logic [3:0]    MAXD   = 4'(MAXVAL);
   localparam logic [CW-1:0] TOPCUR = CW'(NDIG - 1);

   typedef enum logic {ENTRY, REVIEW} state_t;

   state_t     state, state_nxt;
   logic [2:0] sync1, sync2, prev;
   logic [2:0] press;
   logic       ev_inc, ev_adv, ev_clr;
   logic       commit, clear_all;
   logic [3:0] dig [NDIG];

   // Key synchronisers and press-edge detectors; index 0/1/2 = key1/key2/key3.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= '1;
         sync2 <= '1;
         prev  <= '1;
      end else begin
         sync1 <= {key3, key2, key1};
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign press = prev & ~sync2;

   // Only the highest-priority event of a cycle acts.
   assign ev_clr = press[2];
   assign ev_adv = press[1] & ~press[2];
   assign ev_inc = press[0] & ~press[1] & ~press[2];

   assign commit    = (state == REVIEW) && ev_adv;
   assign clear_all = ev_clr | commit;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ENTRY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ENTRY: begin
            if (!ev_clr && ev_adv && cursor == '0) begin
               state_nxt = REVIEW;
            end
         end
         REVIEW: begin
            if (ev_clr || ev_adv) begin
               state_nxt = ENTRY;
            end
         end
         default: state_nxt = ENTRY;
      endcase
   end

   always_comb begin
      review = (state == REVIEW);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < NDIG; k++) begin
            dig[k] <= '0;
         end
         cursor <= TOPCUR;
         code   <= '0;
         done   <= 1'b0;
      end else begin
         done <= commit;
         if (commit) begin
            code <= bcd;
         end
         if (clear_all) begin
            for (int unsigned k = 0; k < NDIG; k++) begin
               dig[k] <= '0;
            end
            cursor <= TOPCUR;
         end else if (state == ENTRY) begin
            if (ev_adv && cursor != '0) begin
               cursor <= cursor - CW'(1);
            end
            if (ev_inc) begin
               for (int unsigned k = 0; k < NDIG; k++) begin
                  // Explicit wrap compare; 4-bit overflow is never relied on.
                  if (cursor == CW'(k)) begin
                     dig[k] <= (dig[k] == MAXD) ? 4'd0 : dig[k] + 4'd1;
                  end
               end
            end
         end
      end
   end

   function automatic logic [6:0] seg7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   always_comb begin
      bcd = '0;
      hex = '1;
      for (int unsigned k = 0; k < NDIG; k++) begin
         bcd[4*k +: 4] = dig[k];
         hex[7*k +: 7] = seg7(dig[k]);
      end
   end

endmodule

// File: tb/tb_digit_entry.sv
// Randomised and directed bench for digit_entry, checked every cycle against
// a behavioural model driven by the sampled key history.
module tb_digit_entry;

   localparam int NDIG   = 2;
   localparam int MAXVAL = 9;
   localparam int CW     = 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              key1 = 1'b1, key2 = 1'b1, key3 = 1'b1;
   logic [4*NDIG-1:0] bcd, code;
   logic [7*NDIG-1:0] hex;
   logic [CW-1:0]     cursor;
   logic              review, done;

   digit_entry #(.NDIG(NDIG), .MAXVAL(MAXVAL)) dut (
      .clk(clk), .rst_n(rst_n), .key1(key1), .key2(key2), .key3(key3),
      .bcd(bcd), .hex(hex), .cursor(cursor), .review(review),
      .code(code), .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model state
   int md [NDIG];
   int mcur;
   bit mrev;
   int mcode;
   bit mdone;
   bit h1 [3], h2 [3], h3 [3];   // key levels sampled 1, 2, 3 edges ago

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] segof(input int v);
      case (v)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic int packed_val();
      int r = 0;
      for (int k = NDIG - 1; k >= 0; k--) r = r * 16 + md[k];
      return r;
   endfunction

   function automatic logic [63:0] hex_val();
      logic [63:0] r = '0;
      for (int k = 0; k < NDIG; k++) r[7*k +: 7] = segof(md[k]);
      return r;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < NDIG; k++) md[k] = 0;
      mcur = NDIG - 1;
   endtask

   task automatic model_edge(input bit r, input bit k1, input bit k2, input bit k3);
      bit ev [3];
      bit cur [3];
      cur[0] = k1; cur[1] = k2; cur[2] = k3;
      mdone = 0;
      if (!r) begin
         model_clear();
         mrev = 0;
         mcode = 0;
         for (int j = 0; j < 3; j++) begin h1[j] = 1; h2[j] = 1; h3[j] = 1; end
      end else begin
         // A key acts two edges after its first low sample.
         for (int j = 0; j < 3; j++) begin
            ev[j] = h3[j] && !h2[j];
            h3[j] = h2[j]; h2[j] = h1[j]; h1[j] = cur[j];
         end
         if (ev[2]) begin
            model_clear();
            mrev = 0;
         end else if (ev[1]) begin
            if (mrev) begin
               mcode = packed_val();
               mdone = 1;
               model_clear();
               mrev = 0;
            end else if (mcur > 0) begin
               mcur--;
            end else begin
               mrev = 1;
            end
         end else if (ev[0] && !mrev) begin
            md[mcur] = (md[mcur] == MAXVAL) ? 0 : md[mcur] + 1;
         end
      end
   endtask

   task automatic compare_all();
      chk("bcd", 64'(bcd), 64'(packed_val()));
      chk("hex", 64'(hex), hex_val());
      chk("cursor", 64'(cursor), 64'(mcur));
      chk("review", 64'(review), 64'(mrev));
      chk("code", 64'(code), 64'(mcode));
      chk("done", 64'(done), 64'(mdone));
   endtask

   task automatic step(input bit k1, input bit k2, input bit k3, input bit r);
      @(negedge clk);
      key1 = k1; key2 = k2; key3 = k3; rst_n = r;
      @(posedge clk);
      model_edge(r, k1, k2, k3);
      #1;
      compare_all();
   endtask

   // Hold one key low for 'hold' cycles, then release long enough for the event to land.
   task automatic press(input int which, input int hold);
      for (int h = 0; h < hold; h++) step(which != 1, which != 2, which != 3, 1'b1);
      step(1, 1, 1, 1);
      step(1, 1, 1, 1);
   endtask

   task automatic press_n(input int which, input int n);
      for (int i = 0; i < n; i++) press(which, 1);
   endtask

   initial begin
      step(1, 1, 1, 0);
      step(1, 1, 1, 0);
      chk("rst_bcd", 64'(bcd), 64'h00);
      chk("rst_hex", 64'(hex), 64'(14'b1000000_1000000));
      chk("rst_cursor", 64'(cursor), 64'd1);
      chk("rst_review", 64'(review), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_code", 64'(code), 64'h00);

      // Latency: first low sample at edge m, result after edge m+2
      step(0, 1, 1, 1);
      chk("lat_m", 64'(bcd), 64'h00);
      step(1, 1, 1, 1);
      chk("lat_m1", 64'(bcd), 64'h00);
      step(1, 1, 1, 1);
      chk("lat_m2", 64'(bcd), 64'h10);
      press_n(1, 2);
      chk("inc3_bcd", 64'(bcd), 64'h30);
      chk("inc3_hex1", 64'(hex[13:7]), 64'(7'b0110000));

      press(1, 20);
      chk("hold20", 64'(bcd), 64'h40);

      press(3, 1);
      press_n(1, 11);
      chk("wrap", 64'(bcd), 64'h10);

      press(3, 1);
      press_n(1, 3);
      press(2, 1);
      press_n(1, 7);
      chk("entry_bcd", 64'(bcd), 64'h37);
      chk("entry_cursor", 64'(cursor), 64'd0);
      press(2, 1);
      chk("to_review", 64'(review), 64'd1);
      press(2, 1);
      chk("commit_done", 64'(done), 64'd1);
      chk("commit_code", 64'(code), 64'h37);
      chk("commit_bcd", 64'(bcd), 64'h00);
      chk("commit_cursor", 64'(cursor), 64'd1);
      chk("commit_review", 64'(review), 64'd0);
      step(1, 1, 1, 1);
      chk("done_pulse", 64'(done), 64'd0);

      press_n(1, 5);
      press(2, 1);
      press_n(1, 2);
      chk("pre_clear", 64'(bcd), 64'h52);
      press(3, 1);
      chk("clear_bcd", 64'(bcd), 64'h00);
      chk("clear_cursor", 64'(cursor), 64'd1);

      press_n(2, 2);
      chk("prio_review", 64'(review), 64'd1);
      step(1, 0, 0, 1);
      step(1, 1, 1, 1);
      step(1, 1, 1, 1);
      chk("prio_done", 64'(done), 64'd0);
      chk("prio_code", 64'(code), 64'h37);
      chk("prio_review_off", 64'(review), 64'd0);

      press_n(1, 4);
      press(2, 1);
      press(1, 1);
      press(2, 1);
      chk("rr_review", 64'(review), 64'd1);
      chk("rr_bcd", 64'(bcd), 64'h41);
      step(1, 1, 1, 0);
      chk("rr_code", 64'(code), 64'h00);
      chk("rr_bcd0", 64'(bcd), 64'h00);
      chk("rr_review0", 64'(review), 64'd0);
      chk("rr_done", 64'(done), 64'd0);
      step(1, 1, 1, 1);

      for (int i = 0; i < 4000; i++) begin
         bit r, a, b, c;
         r = ($urandom_range(0, 299) != 0);
         a = ($urandom_range(0, 2) != 0);
         b = ($urandom_range(0, 4) != 0);
         c = ($urandom_range(0, 19) != 0);
         step(a, b, c, r);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
